// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: enable-based SCK divider, all CPOL/CPHA modes, MSB/LSB ordering
// and one-hot active-low slave selects, all in the clk domain.
module spi_master_cfg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              SPI_reset,
    input  logic              SPI_start,
    input  logic [DATA_W-1:0] SPI_data_trans,
    input  logic              SPI_MSB,
    input  logic              SPI_cpol,
    input  logic              SPI_cpha,
    input  logic [DIV_W-1:0]  SPI_div,
    input  logic [SS_W-1:0]   SPI_ss_sel,
    input  logic              SPI_miso,
    output logic              SPI_sck,
    output logic              SPI_mosi,
    output logic [NUM_SS-1:0] SPI_slave_select,
    output logic [DATA_W-1:0] SPI_data_rec,
    output logic              SPI_flag,
    output logic              SPI_done
);

    localparam int unsigned HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] LastHalf = HP_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [HP_W-1:0]   half_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              msb_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [NUM_SS-1:0] ss_dec;
    logic              half_end;
    logic              leading;
    logic              do_sample;
    logic              do_drive;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic msb);
        return msb ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic msb);
        return msb ? (w << 1) : (w >> 1);
    endfunction

    // Out-of-range indices match no line, so the transfer runs with every select high.
    always_comb begin
        ss_dec = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (SPI_ss_sel == SS_W'(i)) begin
                ss_dec[i] = 1'b0;
            end
        end
    end

    // Even half-period indices end on a leading edge; the last trailing edge never drives.
    assign half_end  = (cnt_q == div_q);
    assign leading   = ~half_q[0];
    assign do_sample = leading ^ cpha_q;
    assign do_drive  = ~do_sample & ~((half_q == LastHalf) & ~cpha_q);

    always_ff @(posedge clk) begin
        if (SPI_reset) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            div_q            <= '0;
            half_q           <= '0;
            tx_q             <= '0;
            rx_q             <= '0;
            msb_q            <= 1'b0;
            cpol_q           <= 1'b0;
            cpha_q           <= 1'b0;
            SPI_sck          <= 1'b0;
            SPI_mosi         <= 1'b0;
            SPI_slave_select <= '1;
            SPI_data_rec     <= '0;
            SPI_flag         <= 1'b0;
            SPI_done         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    SPI_sck          <= SPI_cpol;
                    SPI_mosi         <= 1'b0;
                    SPI_slave_select <= '1;
                    SPI_flag         <= 1'b0;
                    SPI_done         <= 1'b0;
                    if (SPI_start) begin
                        msb_q            <= SPI_MSB;
                        cpol_q           <= SPI_cpol;
                        cpha_q           <= SPI_cpha;
                        div_q            <= SPI_div;
                        cnt_q            <= '0;
                        rx_q             <= '0;
                        // cpha=0 presents the first bit now, so it is pre-shifted out of tx_q
                        tx_q             <= SPI_cpha ? SPI_data_trans
                                                     : shift_out(SPI_data_trans, SPI_MSB);
                        SPI_mosi         <= ~SPI_cpha & head_bit(SPI_data_trans, SPI_MSB);
                        SPI_slave_select <= ss_dec;
                        SPI_flag         <= 1'b1;
                        state_q          <= StSetup;
                    end
                end
                StSetup: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        half_q  <= '0;
                        state_q <= StXfer;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                StXfer: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        half_q  <= half_q + HP_W'(1);
                        SPI_sck <= ~SPI_sck;
                        if (do_sample) begin
                            rx_q <= msb_q ? {rx_q[DATA_W-2:0], SPI_miso}
                                          : {SPI_miso, rx_q[DATA_W-1:1]};
                        end
                        if (do_drive) begin
                            SPI_mosi <= head_bit(tx_q, msb_q);
                            tx_q     <= shift_out(tx_q, msb_q);
                        end
                        if (half_q == LastHalf) begin
                            state_q <= StHold;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                StHold: begin
                    SPI_sck <= cpol_q;
                    if (half_end) begin
                        cnt_q            <= '0;
                        SPI_sck          <= SPI_cpol;
                        SPI_mosi         <= 1'b0;
                        SPI_slave_select <= '1;
                        SPI_data_rec     <= rx_q;
                        SPI_flag         <= 1'b0;
                        SPI_done         <= 1'b1;
                        state_q          <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: behavioural SPI slave, loopback and timing checks
// on an 8-bit/4-select instance and a 16-bit/1-select instance.
module tb_spi_master_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    // 8-bit instance
    logic       s8_start = 1'b0;
    logic [7:0] s8_data = 8'h00;
    logic       s8_msb = 1'b1, s8_cpol = 1'b0, s8_cpha = 1'b0;
    logic [7:0] s8_div = 8'h00;
    logic [1:0] s8_sel = 2'd0;
    logic       s8_miso;
    logic       s8_sck, s8_mosi, s8_flag, s8_done;
    logic [3:0] s8_ss;
    logic [7:0] s8_rec;
    // 16-bit instance, always looped back
    logic        s16_start = 1'b0;
    logic [15:0] s16_data = 16'h0000;
    logic        s16_msb = 1'b1;
    logic [7:0]  s16_div = 8'h00;
    logic        s16_sel = 1'b0;
    logic        s16_sck, s16_mosi, s16_flag, s16_done;
    logic [0:0]  s16_ss;
    logic [15:0] s16_rec;

    int errors = 0;
    int checks = 0;

    spi_master_cfg #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u_dut8 (
        .clk(clk), .SPI_reset(rst), .SPI_start(s8_start), .SPI_data_trans(s8_data),
        .SPI_MSB(s8_msb), .SPI_cpol(s8_cpol), .SPI_cpha(s8_cpha), .SPI_div(s8_div),
        .SPI_ss_sel(s8_sel), .SPI_miso(s8_miso), .SPI_sck(s8_sck), .SPI_mosi(s8_mosi),
        .SPI_slave_select(s8_ss), .SPI_data_rec(s8_rec), .SPI_flag(s8_flag),
        .SPI_done(s8_done)
    );

    spi_master_cfg #(.DATA_W(16), .NUM_SS(1), .DIV_W(8)) u_dut16 (
        .clk(clk), .SPI_reset(rst), .SPI_start(s16_start), .SPI_data_trans(s16_data),
        .SPI_MSB(s16_msb), .SPI_cpol(1'b0), .SPI_cpha(1'b0), .SPI_div(s16_div),
        .SPI_ss_sel(s16_sel), .SPI_miso(s16_mosi), .SPI_sck(s16_sck), .SPI_mosi(s16_mosi),
        .SPI_slave_select(s16_ss), .SPI_data_rec(s16_rec), .SPI_flag(s16_flag),
        .SPI_done(s16_done)
    );

    // Behavioural slave: reacts to SCK edges it observes while any select is low.
    logic       loopback = 1'b0;
    logic       sl_cpol = 1'b0, sl_cpha = 1'b0, sl_msb = 1'b1;
    logic [7:0] sl_word = 8'h00, sl_rx = 8'h00;
    int         sl_tx_idx = 0, sl_rx_idx = 0;
    logic       sl_miso = 1'b0, sl_prev_sck = 1'b0, sl_prev_act = 1'b0;
    logic       sl_act;

    assign sl_act  = (s8_ss != 4'hF);
    assign s8_miso = loopback ? s8_mosi : sl_miso;

    always @(negedge clk) begin
        if (sl_act && !sl_prev_act) begin
            sl_rx_idx <= 0;
            sl_rx     <= 8'h00;
            sl_tx_idx <= sl_cpha ? 0 : 1;
            sl_miso   <= sl_cpha ? 1'b0 : sl_word[sl_msb ? 7 : 0];
        end else if (sl_act && s8_sck != sl_prev_sck) begin
            if ((s8_sck != sl_cpol) == !sl_cpha) begin
                sl_rx[sl_msb ? 7 - sl_rx_idx : sl_rx_idx] <= s8_mosi;
                sl_rx_idx <= sl_rx_idx + 1;
            end else if (sl_tx_idx < 8) begin
                sl_miso   <= sl_word[sl_msb ? 7 - sl_tx_idx : sl_tx_idx];
                sl_tx_idx <= sl_tx_idx + 1;
            end
        end
        sl_prev_sck <= s8_sck;
        sl_prev_act <= sl_act;
    end

    // Runs one 8-bit transfer starting at the current negedge (cycle 0) and measures it.
    task automatic do_xfer(input logic cpol, input logic cpha, input logic msb,
                           input logic [7:0] div, input logic [7:0] data,
                           input logic [7:0] word, input logic [1:0] sel, input int mid_cyc,
                           output int done_cyc, output int rises, output logic [3:0] ss_and,
                           output logic [3:0] first_ss, output int bad_mosi, output int tail);
        logic psck, pmosi;
        int   last_edge, budget;
        s8_cpol = cpol; s8_cpha = cpha; s8_msb = msb; s8_div = div;
        s8_data = data; s8_sel = sel; s8_start = 1'b1;
        sl_cpol = cpol; sl_cpha = cpha; sl_msb = msb; sl_word = word;
        done_cyc = -1; rises = 0; ss_and = 4'hF; first_ss = 4'hF; bad_mosi = 0;
        last_edge = 0; psck = s8_sck; pmosi = s8_mosi;
        budget = 1 + 18 * (int'(div) + 1) + 20;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) s8_start = 1'b0;
            if (c == mid_cyc) begin
                s8_start = 1'b1; s8_data = ~data; s8_cpol = ~cpol; s8_div = 8'h00;
                s8_msb = ~msb; s8_cpha = ~cpha;
            end
            if (c == mid_cyc + 1) begin
                s8_start = 1'b0; s8_data = data; s8_cpol = cpol; s8_div = div;
                s8_msb = msb; s8_cpha = cpha;
            end
            if (c == 1) first_ss = s8_ss;
            ss_and &= s8_ss;
            if (s8_sck != psck) begin
                if (s8_sck) rises++;
                last_edge = c;
            end
            // mosi may only move on an SCK edge of the driving kind (leading iff cpha=1)
            if (s8_mosi != pmosi && c > 1 && !s8_done) begin
                if (s8_sck == psck) bad_mosi++;
                else if ((s8_sck != cpol) != cpha) bad_mosi++;
            end
            psck = s8_sck; pmosi = s8_mosi;
            if (s8_done) begin
                done_cyc = c;
                break;
            end
        end
        tail = done_cyc - last_edge;
    endtask

    task automatic idle_mode(input logic cpol);
        s8_cpol = cpol;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s8_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", s8_sck); end
        checks++; if (s8_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", s8_mosi); end
        checks++; if (s8_ss !== 4'hF) begin errors++; $display("FAIL reset_ss got %h want f", s8_ss); end
        checks++; if (s8_rec !== 8'h00) begin errors++; $display("FAIL reset_rec got %h want 00", s8_rec); end
        checks++; if ({s8_flag, s8_done} !== 2'b00) begin errors++; $display("FAIL reset_flag_done got %b want 00", {s8_flag, s8_done}); end
        checks++; if ({s16_ss, s16_flag, s16_done, s16_rec} !== {1'b1, 2'b00, 16'h0}) begin
            errors++; $display("FAIL reset_dut16 got ss=%b flag=%b done=%b rec=%h want 1 0 0 0000",
                               s16_ss, s16_flag, s16_done, s16_rec);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0_loopback;
        int dc, rs, bm, tl;
        logic [3:0] sa, fs;
        idle_mode(1'b0);
        loopback = 1'b1;
        checks++; if (s8_sck !== 1'b0) begin errors++; $display("FAIL m0_idle_sck got %b want 0", s8_sck); end
        do_xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'hA5, 8'h00, 2'd0, -1, dc, rs, sa, fs, bm, tl);
        checks++; if (s8_rec !== 8'hA5) begin errors++; $display("FAIL m0_rec got %h want a5", s8_rec); end
        checks++; if (dc != 19) begin errors++; $display("FAIL m0_done_cycle got %0d want 19", dc); end
        checks++; if (rs != 8) begin errors++; $display("FAIL m0_sck_rises got %0d want 8", rs); end
        checks++; if (sa !== 4'b1110) begin errors++; $display("FAIL m0_ss got %b want 1110", sa); end
        checks++; if (bm != 0) begin errors++; $display("FAIL m0_mosi_edges got %0d bad want 0", bm); end
        checks++; if (tl != 1) begin errors++; $display("FAIL m0_deselect_gap got %0d want 1", tl); end
        checks++; if (s8_flag !== 1'b0) begin errors++; $display("FAIL m0_flag_at_done got %b want 0", s8_flag); end
        @(negedge clk);
        checks++; if ({s8_done, s8_rec} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL m0_done_pulse got done=%b rec=%h want 0 a5", s8_done, s8_rec);
        end
        loopback = 1'b0;
    endtask

    task automatic test_mode3_slave;
        int dc, rs, bm, tl;
        logic [3:0] sa, fs;
        idle_mode(1'b1);
        checks++; if (s8_sck !== 1'b1) begin errors++; $display("FAIL m3_idle_sck got %b want 1", s8_sck); end
        do_xfer(1'b1, 1'b1, 1'b0, 8'd3, 8'h81, 8'h3C, 2'd2, -1, dc, rs, sa, fs, bm, tl);
        checks++; if (s8_rec !== 8'h3C) begin errors++; $display("FAIL m3_rec got %h want 3c", s8_rec); end
        checks++; if (sl_rx !== 8'h81 || sl_rx_idx != 8) begin
            errors++; $display("FAIL m3_slave_rx got %h (%0d bits) want 81 (8 bits)", sl_rx, sl_rx_idx);
        end
        checks++; if (sa !== 4'b1011) begin errors++; $display("FAIL m3_ss got %b want 1011", sa); end
        checks++; if (dc != 73) begin errors++; $display("FAIL m3_done_cycle got %0d want 73", dc); end
        checks++; if (bm != 0) begin errors++; $display("FAIL m3_mosi_edges got %0d bad want 0", bm); end
        checks++; if (tl != 4) begin errors++; $display("FAIL m3_deselect_gap got %0d want 4", tl); end
        @(negedge clk);
        checks++; if (s8_sck !== 1'b1) begin errors++; $display("FAIL m3_after_sck got %b want 1", s8_sck); end
    endtask

    task automatic test_modes12;
        int dc, rs, bm, tl;
        logic [3:0] sa, fs;
        for (int m = 1; m <= 2; m++) begin
            logic cp, ch;
            cp = (m == 2); ch = (m == 1);
            idle_mode(cp);
            checks++; if (s8_sck !== cp) begin errors++; $display("FAIL mode%0d_idle_before got %b want %b", m, s8_sck, cp); end
            do_xfer(cp, ch, 1'b1, 8'd1, 8'h5A, 8'h5A, 2'd1, -1, dc, rs, sa, fs, bm, tl);
            checks++; if (s8_rec !== 8'h5A || sl_rx !== 8'h5A) begin
                errors++; $display("FAIL mode%0d_data got rec=%h slave=%h want 5a 5a", m, s8_rec, sl_rx);
            end
            checks++; if (bm != 0) begin errors++; $display("FAIL mode%0d_mosi_edges got %0d bad want 0", m, bm); end
            checks++; if (rs != 8) begin errors++; $display("FAIL mode%0d_sck_rises got %0d want 8", m, rs); end
            @(negedge clk);
            checks++; if (s8_sck !== cp) begin errors++; $display("FAIL mode%0d_idle_after got %b want %b", m, s8_sck, cp); end
        end
    endtask

    task automatic test_back_to_back;
        int dc, rs, bm, tl, flag_seen;
        logic [3:0] sa, fs;
        logic [7:0] d1, w1, d2, w2;
        d1 = 8'($urandom); w1 = 8'($urandom); d2 = 8'($urandom); w2 = 8'($urandom);
        idle_mode(1'b0);
        do_xfer(1'b0, 1'b0, 1'b1, 8'd1, d1, w1, 2'd3, -1, dc, rs, sa, fs, bm, tl);
        checks++; if (s8_rec !== w1 || sl_rx !== d1) begin
            errors++; $display("FAIL b2b_first got rec=%h slave=%h want %h %h", s8_rec, sl_rx, w1, d1);
        end
        checks++; if (s8_ss !== 4'hF) begin errors++; $display("FAIL b2b_gap_ss got %b want 1111", s8_ss); end
        do_xfer(1'b0, 1'b0, 1'b1, 8'd1, d2, w2, 2'd0, 5, dc, rs, sa, fs, bm, tl);
        checks++; if (fs !== 4'b1110) begin errors++; $display("FAIL b2b_second_select got %b want 1110", fs); end
        checks++; if (dc != 37) begin errors++; $display("FAIL b2b_done_cycle got %0d want 37", dc); end
        checks++; if (s8_rec !== w2 || sl_rx !== d2) begin
            errors++; $display("FAIL b2b_second got rec=%h slave=%h want %h %h", s8_rec, sl_rx, w2, d2);
        end
        flag_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (s8_flag || s8_done) flag_seen++;
        end
        checks++; if (flag_seen != 0) begin errors++; $display("FAIL b2b_no_queue got %0d busy cycles want 0", flag_seen); end
    endtask

    task automatic test_reset_mid;
        int dc, rs, bm, tl, done_seen;
        logic [3:0] sa, fs;
        logic [7:0] w;
        w = 8'($urandom) | 8'h01;
        idle_mode(1'b0);
        s8_cpha = 1'b0; s8_msb = 1'b1; s8_div = 8'd0; s8_data = 8'h3E; s8_sel = 2'd1;
        sl_cpol = 1'b0; sl_cpha = 1'b0; sl_msb = 1'b1; sl_word = w; s8_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) s8_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({s8_sck, s8_mosi, s8_flag, s8_done} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_bits got sck=%b mosi=%b flag=%b done=%b want 0000",
                               s8_sck, s8_mosi, s8_flag, s8_done);
        end
        checks++; if (s8_ss !== 4'hF) begin errors++; $display("FAIL rstmid_ss got %b want 1111", s8_ss); end
        checks++; if (s8_rec !== 8'h00) begin errors++; $display("FAIL rstmid_rec got %h want 00", s8_rec); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (s8_done) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_seen); end
        do_xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'hC3, 8'h96, 2'd1, -1, dc, rs, sa, fs, bm, tl);
        checks++; if (s8_rec !== 8'h96 || sl_rx !== 8'hC3 || dc != 19) begin
            errors++; $display("FAIL rstmid_after got rec=%h slave=%h done=%0d want 96 c3 19",
                               s8_rec, sl_rx, dc);
        end
    endtask

    task automatic test_random;
        int dc, rs, bm, tl;
        logic [3:0] sa, fs, exp_ss;
        for (int i = 0; i < 12; i++) begin
            logic cp, ch, mb;
            logic [7:0] dv, d, w;
            logic [1:0] sel;
            cp = 1'($urandom); ch = 1'($urandom); mb = 1'($urandom);
            dv = 8'($urandom_range(0, 3)); d = 8'($urandom); w = 8'($urandom);
            sel = 2'($urandom);
            exp_ss = 4'hF; exp_ss[sel] = 1'b0;
            idle_mode(cp);
            do_xfer(cp, ch, mb, dv, d, w, sel, -1, dc, rs, sa, fs, bm, tl);
            checks++; if (s8_rec !== w || sl_rx !== d) begin
                errors++; $display("FAIL rand%0d_data got rec=%h slave=%h want %h %h", i, s8_rec, sl_rx, w, d);
            end
            checks++; if (dc != 1 + 18 * (int'(dv) + 1) || tl != int'(dv) + 1) begin
                errors++; $display("FAIL rand%0d_timing got done=%0d gap=%0d want %0d %0d",
                                   i, dc, tl, 1 + 18 * (int'(dv) + 1), int'(dv) + 1);
            end
            checks++; if (sa !== exp_ss || bm != 0) begin
                errors++; $display("FAIL rand%0d_ss_mosi got ss=%b badmosi=%0d want %b 0", i, sa, bm, exp_ss);
            end
        end
    endtask

    task automatic test_wide;
        for (int k = 0; k < 2; k++) begin
            int dc;
            logic ss_low;
            s16_sel = (k == 1); s16_msb = (k == 0); s16_div = 8'd1; s16_data = 16'hBEEF;
            s16_start = 1'b1;
            dc = -1; ss_low = 1'b0;
            for (int c = 1; c <= 100; c++) begin
                @(negedge clk);
                if (c == 1) s16_start = 1'b0;
                if (s16_ss == 1'b0) ss_low = 1'b1;
                if (s16_done) begin
                    dc = c;
                    break;
                end
            end
            checks++; if (s16_rec !== 16'hBEEF) begin errors++; $display("FAIL wide%0d_rec got %h want beef", k, s16_rec); end
            checks++; if (dc != 69) begin errors++; $display("FAIL wide%0d_done_cycle got %0d want 69", k, dc); end
            checks++; if (ss_low !== (k == 0)) begin
                errors++; $display("FAIL wide%0d_select got low=%b want %b", k, ss_low, (k == 0));
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_modes12();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
